// File: rtl/fetch_buffer.sv
// rtl/fetch_buffer.sv - instruction fetch front-end with in-order req/gnt/rvalid bus and a DEPTH-entry instr/PC FIFO
module fetch_buffer #(
   parameter int          DEPTH    = 4,
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        PCSrcE,
   input  logic [31:0] PCTargetE,
   input  logic        StallD,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_gnt,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   output logic        ValidF,
   output logic [31:0] InstrF,
   output logic [31:0] PCF,
   output logic [31:0] PCPlus4F
);

   localparam int          PW      = $clog2(DEPTH);
   localparam int          CW      = $clog2(DEPTH + 1);
   localparam logic [CW:0] DEPTH_C = (CW + 1)'(DEPTH);
   localparam logic [CW-1:0] FULL  = CW'(DEPTH);
   localparam logic [31:0] NOP     = 32'h0000_0013;

   logic [31:0]   fetch_pc;
   logic [31:0]   resp_pc;
   logic [31:0]   instr_mem [DEPTH];
   logic [31:0]   pc_mem    [DEPTH];
   logic [PW-1:0] rd_ptr;
   logic [PW-1:0] wr_ptr;
   logic [CW-1:0] count;
   logic [CW-1:0] outstanding;
   logic [CW-1:0] drop_cnt;
   logic          run;
   logic          accept;
   logic          fill;
   logic          pop;
   logic [31:0]   target;
   logic [CW:0]   in_use;

   assign target    = PCTargetE & 32'hFFFF_FFFC;
   assign in_use    = {1'b0, count} + {1'b0, outstanding};
   // run holds off the first request until the first edge after reset release
   assign imem_req  = run & ~PCSrcE & (in_use < DEPTH_C);
   assign imem_addr = fetch_pc;
   assign accept    = imem_req & imem_gnt;
   assign fill      = imem_rvalid & ~PCSrcE & (drop_cnt == '0);
   assign pop       = ValidF & ~StallD & ~PCSrcE;

   assign ValidF   = (count != '0);
   assign InstrF   = ValidF ? instr_mem[rd_ptr] : NOP;
   assign PCF      = ValidF ? pc_mem[rd_ptr] : 32'd0;
   assign PCPlus4F = ValidF ? pc_mem[rd_ptr] + 32'd4 : 32'd0;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         run         <= 1'b0;
         fetch_pc    <= RESET_PC;
         resp_pc     <= RESET_PC;
         rd_ptr      <= '0;
         wr_ptr      <= '0;
         count       <= '0;
         outstanding <= '0;
         drop_cnt    <= '0;
      end else begin
         run <= 1'b1;
         if (PCSrcE) begin
            // every request still in flight belongs to the old stream
            fetch_pc    <= target;
            resp_pc     <= target;
            rd_ptr      <= wr_ptr;
            count       <= '0;
            outstanding <= outstanding - CW'(imem_rvalid);
            drop_cnt    <= outstanding - CW'(imem_rvalid);
         end else begin
            if (accept)
               fetch_pc <= fetch_pc + 32'd4;
            outstanding <= outstanding + CW'(accept) - CW'(imem_rvalid);
            if (imem_rvalid && drop_cnt != '0)
               drop_cnt <= drop_cnt - CW'(1);
            if (fill) begin
               wr_ptr  <= wr_ptr + PW'(1);
               resp_pc <= resp_pc + 32'd4;
            end
            if (pop)
               rd_ptr <= rd_ptr + PW'(1);
            count <= count + CW'(fill) - CW'(pop);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (fill) begin
         instr_mem[wr_ptr] <= imem_rdata;
         pc_mem[wr_ptr]    <= resp_pc;
      end
   end

   assert property (@(posedge clk) disable iff (!reset) fill |-> (count != FULL));

endmodule

// File: tb/tb_fetch_buffer.sv
// tb/tb_fetch_buffer.sv - bench for fetch_buffer: epoch-tagged memory/queue model plus directed literal checks
module tb_fetch_buffer;

   logic        clk = 1'b0;
   logic        reset;
   logic        PCSrcE;
   logic [31:0] PCTargetE;
   logic        StallD;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_gnt;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic        ValidF;
   logic [31:0] InstrF;
   logic [31:0] PCF;
   logic [31:0] PCPlus4F;

   fetch_buffer #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
      .clk(clk), .reset(reset), .PCSrcE(PCSrcE), .PCTargetE(PCTargetE), .StallD(StallD),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
      .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
      .ValidF(ValidF), .InstrF(InstrF), .PCF(PCF), .PCPlus4F(PCPlus4F)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] addr;
      int          ep;
      int          ready;
   } pend_t;

   int          total = 0;
   int          bad   = 0;
   int          cyc   = 0;
   int          epoch = 0;
   bit          run   = 0;
   logic [31:0] next_addr = 32'h0;
   logic [31:0] exp_q[$];
   pend_t       pending[$];
   int          rmin = 0, rmax = 0, gmax = 0, wait_left = 0;

   bit          obs_valid, obs_req;
   logic [31:0] obs_pc, obs_instr, obs_addr;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at cyc %0d", name, act, exp, cyc);
      end
   endtask

   // one cycle: drive inputs after negedge, compare against the model, then advance the model at posedge
   task automatic step(input bit pcsrc, input logic [31:0] tgt, input bit stall);
      bit    exp_req, rv, granted;
      int    n_old;
      pend_t r;
      PCSrcE    = pcsrc;
      PCTargetE = tgt;
      StallD    = stall;
      rv = (pending.size() > 0) && (pending[0].ready <= cyc);
      imem_rvalid = rv;
      imem_rdata  = rv ? ~pending[0].addr : 32'hDEAD_BEEF;
      #1;
      imem_gnt = 1'b0;
      if (imem_req) begin
         if (wait_left == 0) imem_gnt = 1'b1;
         else wait_left--;
      end
      #1;
      exp_req = run && !pcsrc && (exp_q.size() + pending.size() < 4);
      chk("imem_req", imem_req, exp_req);
      if (exp_req) chk("imem_addr", imem_addr, next_addr);
      if (exp_q.size() > 0) begin
         chk("ValidF", ValidF, 1);
         chk("PCF", PCF, exp_q[0]);
         chk("InstrF", InstrF, ~exp_q[0]);
         chk("PCPlus4F", PCPlus4F, exp_q[0] + 32'd4);
      end else begin
         chk("ValidF", ValidF, 0);
         chk("InstrF_nop", InstrF, 32'h0000_0013);
         chk("PCF_zero", PCF, 0);
         chk("PCPlus4F_zero", PCPlus4F, 0);
      end
      n_old = 0;
      foreach (pending[i]) if (pending[i].ep != epoch) n_old++;
      chk("outstanding", dut.outstanding, pending.size());
      chk("drop_cnt", dut.drop_cnt, n_old);
      chk("count", dut.count, exp_q.size());
      obs_valid = ValidF; obs_req = imem_req; obs_pc = PCF; obs_instr = InstrF; obs_addr = imem_addr;
      @(posedge clk);
      granted = obs_req && imem_gnt;
      if (!pcsrc && !stall && exp_q.size() > 0) void'(exp_q.pop_front());
      if (rv) begin
         r = pending.pop_front();
         if (!pcsrc && r.ep == epoch) exp_q.push_back(r.addr);
      end
      if (granted) begin
         pending.push_back('{next_addr, epoch, cyc + 1 + $urandom_range(rmax, rmin)});
         next_addr = next_addr + 32'd4;
         wait_left = $urandom_range(gmax, 0);
      end
      if (pcsrc) begin
         exp_q.delete();
         epoch++;
         next_addr = tgt & 32'hFFFF_FFFC;
      end
      run = 1;
      cyc++;
      @(negedge clk);
   endtask

   task automatic run_until_valid(input int limit);
      bit found = 0;
      for (int i = 0; i < limit && !found; i++) begin
         step(0, 32'h0, 0);
         found = obs_valid;
      end
      chk("wait_valid", found, 1);
   endtask

   initial begin
      int first_cyc, n;
      logic [31:0] first_pc, frozen;
      bit hit;
      reset = 1'b0; PCSrcE = 0; PCTargetE = 0; StallD = 0;
      imem_gnt = 0; imem_rvalid = 0; imem_rdata = 0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_req", imem_req, 0);
      chk("rst_valid", ValidF, 0);
      chk("rst_instr", InstrF, 32'h0000_0013);
      chk("rst_pc", PCF, 0);
      chk("rst_pc4", PCPlus4F, 0);
      reset = 1'b1;

      // zero-wait stream
      first_cyc = -1; first_pc = 32'hFFFF_FFFF;
      for (int i = 0; i < 12; i++) begin
         step(0, 32'h0, 0);
         if (obs_valid && first_cyc < 0) begin first_cyc = cyc - 1; first_pc = obs_pc; end
      end
      chk("first_valid_cycle", first_cyc, 3);
      chk("first_valid_pc", first_pc, 32'h0);
      chk("stream_pc_cyc11", obs_pc, 32'd32);
      chk("stream_addr_cyc11", obs_addr, 32'd40);

      // stall holds the head while credits run out
      for (int i = 0; i < 10; i++) step(0, 32'h0, 1);
      frozen = obs_pc;
      chk("stall_pc_frozen", frozen, 32'd36);
      chk("stall_req_low", obs_req, 0);
      chk("stall_count_full", dut.count, 4);
      step(0, 32'h0, 0);
      chk("release_head", obs_pc, 32'd36);
      step(0, 32'h0, 0);
      chk("release_next", obs_pc, 32'd40);

      // redirect with three requests outstanding and no response that cycle
      rmin = 3; rmax = 3;
      hit = 0;
      for (int i = 0; i < 40 && !hit; i++) begin
         if (pending.size() == 3 && pending[0].ready > cyc) hit = 1;
         else step(0, 32'h0, 0);
      end
      chk("found_three_outstanding", hit, 1);
      chk("outstanding_before_redirect", dut.outstanding, 3);
      step(1, 32'h0000_0102, 0);
      chk("drop_after_redirect", dut.drop_cnt, 3);
      chk("valid_after_redirect", ValidF, 0);
      step(0, 32'h0, 0);
      chk("redirect_req", obs_req, 1);
      chk("redirect_addr", obs_addr, 32'h0000_0100);
      run_until_valid(20);
      chk("redirect_first_pc", obs_pc, 32'h0000_0100);
      chk("redirect_first_instr", obs_instr, 32'hFFFF_FEFF);

      // redirect in the same cycle as a response
      rmin = 2; rmax = 2;
      hit = 0;
      for (int i = 0; i < 40 && !hit; i++) begin
         if (pending.size() >= 2 && pending[0].ready <= cyc) hit = 1;
         else step(0, 32'h0, 0);
      end
      chk("found_rvalid_cycle", hit, 1);
      n = pending.size();
      step(1, 32'h0000_0800, 0);
      chk("drop_with_rvalid", dut.drop_cnt, n - 1);
      run_until_valid(20);
      chk("rv_redirect_first_pc", obs_pc, 32'h0000_0800);

      // back-to-back redirects, then drain all responses
      rmin = 1; rmax = 1;
      step(1, 32'h0000_0200, 0);
      step(1, 32'h0000_0300, 0);
      run_until_valid(20);
      chk("b2b_first_pc", obs_pc, 32'h0000_0300);
      for (int i = 0; i < 15; i++) step(0, 32'h0, 1);
      chk("b2b_outstanding_zero", dut.outstanding, 0);
      chk("b2b_head_pc", obs_pc, 32'h0000_0304);

      // random bus delays, stalls and redirects
      rmin = 0; rmax = 5; gmax = 5;
      for (int i = 0; i < 800; i++) begin
         if ($urandom_range(24, 0) == 0) step(1, $urandom & 32'h0000_FFFF, $urandom_range(9, 0) < 3);
         else step(0, 32'h0, $urandom_range(9, 0) < 3);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
